digit_entry: RTL and testbench
==============================

Name: digit_entry

Overview:
- Operand-entry front end for the lab boards: turns push-button key presses plus a 4-bit digit on switches into a binary operand for the ALU.
- Inverse of the binary-to-decimal hex display path. It accumulates decimal digits MSD-first into a WIDTH-bit binary value.
- Debounces raw keys, detects press events, and presents a committed value with a valid flag.

Parameters:
- WIDTH, 16, width of accumulated binary value.
- MAX_DIGITS, 5, max digits per entry (≤7).
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a key level (≥2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- key_digit_n  input  1  raw active-low key: append digit_in.
- key_done_n  input  1  raw active-low key: commit entry.
- key_clear_n  input  1  raw active-low key: clear entry.
- digit_in  input  4  digit value from switches, sampled on digit press.
- value  output  WIDTH  accumulated/committed binary value.
- valid  output  1  high while value is committed.
- overflow  output  1  sticky: a digit was rejected because it would exceed 2^WIDTH-1.
- reject  output  1  one-cycle pulse on any rejected digit press.
- digit_count  output  3  digits accepted in current entry.
- bcd_echo  output  4*MAX_DIGITS  accepted digits, newest in [3:0], for display echo.

Behaviour:
- Reset (async, any time, including mid-entry): value=0, valid=0, overflow=0, reject=0, digit_count=0, bcd_echo=0. Sync/debounce state returns to the released (1) level; FSM goes to IDLE.
- Per-key input chain: 2-FF synchronizer, then debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any intermediate bounce restarts the counter.
- Press event: one-cycle pulse on debounced 1→0 transition. Releases generate nothing. Holding a key gives exactly one press.
- Latency: state/outputs update on the clock edge after the press pulse. Raw stable low to output change = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Priority when press pulses coincide in one cycle: clear > done > digit. The lower-priority presses are dropped and do not produce reject.
- FSM states:
  - IDLE: no digits entered.
  - ENTRY: ≥1 digit accepted, not committed.
  - DONE: committed.
- Clear (any state) → IDLE: value, digit_count, bcd_echo, overflow, valid all 0.
- Digit press in IDLE/ENTRY. Reject (reject=1 for one cycle, nothing else changes except overflow) if any of:
  - digit_in>9;
  - digit_count==MAX_DIGITS;
  - value*10+digit_in > 2^WIDTH-1. This case also sets overflow=1.
- Accepted digit: value ← value*10+digit_in (computed at WIDTH+4 bits, then truncated after check), digit_count+1, bcd_echo ← {bcd_echo[...:0],digit_in}, state → ENTRY.
- Done press in IDLE or ENTRY → DONE, valid=1. Committing in IDLE commits 0. Value is frozen in DONE.
- Done press in DONE: ignored.
- Digit press in DONE starts a new entry: the prior value/echo/count/overflow are cleared and the digit is evaluated as first digit of a fresh entry; valid=0 in the same cycle. A rejected first digit leaves state IDLE.
- overflow persists until clear, reset, or new entry from DONE.

Optional Feature:
- Macro HEX_ENTRY_EN.
- Defined: digits 0–F accepted; radix 16 (value ← value*16+digit_in); only the count/range rules reject.
- Undefined: decimal as above, digit_in>9 rejected.

Test Plan:
- DEBOUNCE_CYCLES=4; press digits 1,2,3 then done → value=123, valid=1, digit_count=3, bcd_echo[11:0]=0x123.
- WIDTH=16: digits 6,5,5,3 then 6 → fifth press rejects (reject pulse), overflow=1, value=6553, digit_count=4. Then done → valid=1, value=6553.
- Digits 1,2,3,4,5, then 6 → reject pulse, overflow=0, value=12345, digit_count=5. digit_in=0xA in fresh entry → reject, value unchanged.
- key_digit_n glitches low for 3 cycles (<DEBOUNCE_CYCLES) repeatedly → no press, value unchanged. Held low 20 cycles → exactly one accepted digit.
- Clear and digit debounced in same cycle after value=42 → value=0, digit_count=0, no reject. Done+digit same cycle from ENTRY(7) → DONE with value=7.
- Reset asserted mid-debounce with ENTRY value=98 → all outputs 0 immediately (async). After release, the still-held key generates no press until released and re-pressed.

Source files
------------

// File: rtl/digit_entry.sv
// Keypad operand entry: debounced keys accumulate digits MSD-first into a binary value.
// Define HEX_ENTRY_EN for radix-16 entry (digits 0-F); the default build is decimal.
module digit_entry #(
    parameter int WIDTH           = 16,
    parameter int MAX_DIGITS      = 5,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_digit_n,
    input  logic                    key_done_n,
    input  logic                    key_clear_n,
    input  logic [3:0]              digit_in,
    output logic [WIDTH-1:0]        value,
    output logic                    valid,
    output logic                    overflow,
    output logic                    reject,
    output logic [2:0]              digit_count,
    output logic [4*MAX_DIGITS-1:0] bcd_echo
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EW = 4 * MAX_DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Key index: 0 = digit, 1 = done, 2 = clear.
    logic [2:0]    raw_n_s;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_q, deb_d;
    logic [2:0]    armed_q, armed_d;
    logic [2:0]    press_q, press_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    assign raw_n_s = {key_clear_n, key_done_n, key_digit_n};

    // Debounce next-state. A key is only armed after a full debounce period of released
    // samples, so a key still held across reset cannot produce a press.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            deb_d[k]   = deb_q[k];
            armed_d[k] = armed_q[k];
            press_d[k] = 1'b0;
            cnt_d[k]   = cnt_q[k];
            if (!armed_q[k]) begin
                if (sync2_q[k]) begin
                    if (cnt_q[k] == CNT_LAST) begin
                        armed_d[k] = 1'b1;
                        cnt_d[k]   = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CW'(1);
                    end
                end else begin
                    cnt_d[k] = '0;
                end
            end else if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    deb_d[k]   = sync2_q[k];
                    cnt_d[k]   = '0;
                    press_d[k] = ~sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end else begin
                cnt_d[k] = '0;
            end
        end
    end

    // Synchronizer and debounce registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            deb_q   <= 3'b111;
            armed_q <= 3'b000;
            press_q <= 3'b000;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q <= raw_n_s;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            armed_q <= armed_d;
            press_q <= press_d;
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d, base_value_s;
    logic [2:0]       count_q, count_d, base_count_s;
    logic [EW-1:0]    echo_q, echo_d, base_echo_s;
    logic             valid_q, valid_d, ovf_q, ovf_d, base_ovf_s, reject_q, reject_d;
    logic [WIDTH+3:0] prod_s;
    logic             digit_bad_s, count_bad_s, range_bad_s;

    // Entry FSM and datapath; a digit pressed in DONE is evaluated against an empty entry.
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        count_d  = count_q;
        echo_d   = echo_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        reject_d = 1'b0;
        case (state_q)
            DONE: begin
                base_value_s = '0;
                base_count_s = 3'd0;
                base_echo_s  = '0;
                base_ovf_s   = 1'b0;
            end
            default: begin
                base_value_s = value_q;
                base_count_s = count_q;
                base_echo_s  = echo_q;
                base_ovf_s   = ovf_q;
            end
        endcase
`ifdef HEX_ENTRY_EN
        prod_s      = {base_value_s, 4'h0} + {{WIDTH{1'b0}}, digit_in};
        digit_bad_s = 1'b0;
`else
        prod_s      = ({4'h0, base_value_s} << 3) + ({4'h0, base_value_s} << 1)
                    + {{WIDTH{1'b0}}, digit_in};
        digit_bad_s = (digit_in > 4'd9);
`endif
        count_bad_s = (base_count_s == 3'(MAX_DIGITS));
        range_bad_s = |prod_s[WIDTH+3:WIDTH];

        if (press_q[2]) begin
            state_d = IDLE;
            value_d = '0;
            count_d = 3'd0;
            echo_d  = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (press_q[1]) begin
            if (state_q != DONE) begin
                state_d = DONE;
                valid_d = 1'b1;
            end else begin
                state_d = state_q;
            end
        end else if (press_q[0]) begin
            state_d = (state_q == DONE) ? IDLE : state_q;
            value_d = base_value_s;
            count_d = base_count_s;
            echo_d  = base_echo_s;
            ovf_d   = base_ovf_s;
            valid_d = 1'b0;
            if (digit_bad_s || count_bad_s || range_bad_s) begin
                reject_d = 1'b1;
                ovf_d    = base_ovf_s | (range_bad_s & ~digit_bad_s & ~count_bad_s);
            end else begin
                state_d = ENTRY;
                value_d = prod_s[WIDTH-1:0];
                count_d = base_count_s + 3'd1;
                echo_d  = {base_echo_s[EW-5:0], digit_in};
            end
        end else begin
            reject_d = 1'b0;
        end
    end

    // Entry state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            value_q  <= '0;
            count_q  <= 3'd0;
            echo_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            count_q  <= count_d;
            echo_q   <= echo_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            reject_q <= reject_d;
        end
    end

    assign value       = value_q;
    assign valid       = valid_q;
    assign overflow    = ovf_q;
    assign reject      = reject_q;
    assign digit_count = count_q;
    assign bcd_echo    = echo_q;

endmodule

// File: tb/tb_digit_entry.sv
// Directed self-checking bench for digit_entry with a short debounce period.
module tb_digit_entry;

    localparam int WIDTH = 16;
    localparam int MAXD  = 5;
    localparam int DEB   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        keys_n = 3'b111;  // {clear, done, digit}
    logic [3:0]        digit_in = 4'd0;
    logic [WIDTH-1:0]  value;
    logic              valid, overflow, reject;
    logic [2:0]        digit_count;
    logic [4*MAXD-1:0] bcd_echo;

    int n_checks = 0;
    int n_fail   = 0;
    int rej_cnt  = 0;
    int rej0     = 0;

    digit_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset),
        .key_digit_n(keys_n[0]), .key_done_n(keys_n[1]), .key_clear_n(keys_n[2]),
        .digit_in(digit_in), .value(value), .valid(valid), .overflow(overflow),
        .reject(reject), .digit_count(digit_count), .bcd_echo(bcd_echo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reject === 1'b1) rej_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press and release the keys selected by mask, holding them long enough to debounce.
    task automatic press(input logic [2:0] mask, input logic [3:0] d);
        digit_in = d;
        keys_n   = ~mask;
        cyc(10);
        keys_n   = 3'b111;
        cyc(10);
    endtask

    task automatic digit(input logic [3:0] d);
        press(3'b001, d);
    endtask

    initial begin
        cyc(3);
        chk("reset_value", 32'(value), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_count", 32'(digit_count), 32'd0);
        chk("reset_echo", 32'(bcd_echo), 32'd0);
        chk("reset_reject", 32'(reject), 32'd0);
        reset = 1'b0;
        cyc(10);

        // 1,2,3 then done
        digit(4'd1); digit(4'd2); digit(4'd3);
        chk("entry_valid_low", 32'(valid), 32'd0);
        press(3'b010, 4'd0);
        chk("v123", 32'(value), 32'd123);
        chk("v123_valid", 32'(valid), 32'd1);
        chk("v123_count", 32'(digit_count), 32'd3);
        chk("v123_echo", 32'(bcd_echo[11:0]), 32'h123);

        // Range overflow at 65536
        press(3'b100, 4'd0);
        chk("clear_value", 32'(value), 32'd0);
        chk("clear_valid", 32'(valid), 32'd0);
        digit(4'd6); digit(4'd5); digit(4'd5); digit(4'd3);
        rej0 = rej_cnt;
        digit(4'd6);
        chk("ovf_reject", 32'(rej_cnt - rej0), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_value", 32'(value), 32'd6553);
        chk("ovf_count", 32'(digit_count), 32'd4);
        press(3'b010, 4'd0);
        chk("ovf_done_valid", 32'(valid), 32'd1);
        chk("ovf_done_value", 32'(value), 32'd6553);

        // Digit from DONE starts a fresh entry; then hit the digit-count limit
        digit(4'd1);
        chk("fresh_ovf", 32'(overflow), 32'd0);
        chk("fresh_valid", 32'(valid), 32'd0);
        chk("fresh_value", 32'(value), 32'd1);
        digit(4'd2); digit(4'd3); digit(4'd4); digit(4'd5);
        chk("v12345", 32'(value), 32'd12345);
        rej0 = rej_cnt;
        digit(4'd6);
        chk("max_reject", 32'(rej_cnt - rej0), 32'd1);
        chk("max_ovf", 32'(overflow), 32'd0);
        chk("max_value", 32'(value), 32'd12345);
        chk("max_count", 32'(digit_count), 32'd5);
        chk("max_echo", 32'(bcd_echo), 32'h12345);

        // Non-decimal digit in a fresh entry
        press(3'b100, 4'd0);
        rej0 = rej_cnt;
        digit(4'hA);
        chk("hexdig_reject", 32'(rej_cnt - rej0), 32'd1);
        chk("hexdig_value", 32'(value), 32'd0);
        chk("hexdig_count", 32'(digit_count), 32'd0);

        // Glitches shorter than the debounce period are ignored
        digit(4'd4);
        rej0 = rej_cnt;
        digit_in = 4'd9;
        for (int i = 0; i < 5; i++) begin
            keys_n = 3'b110; cyc(3);
            keys_n = 3'b111; cyc(3);
        end
        cyc(10);
        chk("glitch_value", 32'(value), 32'd4);
        chk("glitch_count", 32'(digit_count), 32'd1);
        keys_n = 3'b110; cyc(20);
        keys_n = 3'b111; cyc(10);
        chk("hold_value", 32'(value), 32'd49);
        chk("hold_count", 32'(digit_count), 32'd2);
        chk("glitch_no_reject", 32'(rej_cnt - rej0), 32'd0);

        // Clear beats digit in the same cycle
        press(3'b100, 4'd0);
        digit(4'd4); digit(4'd2);
        chk("v42", 32'(value), 32'd42);
        rej0 = rej_cnt;
        press(3'b101, 4'd5);
        chk("clr_dig_value", 32'(value), 32'd0);
        chk("clr_dig_count", 32'(digit_count), 32'd0);
        chk("clr_dig_reject", 32'(rej_cnt - rej0), 32'd0);

        // Done beats digit in the same cycle
        digit(4'd7);
        press(3'b011, 4'd3);
        chk("done_dig_valid", 32'(valid), 32'd1);
        chk("done_dig_value", 32'(value), 32'd7);
        chk("done_dig_count", 32'(digit_count), 32'd1);

        // Commit from IDLE commits zero
        press(3'b100, 4'd0);
        press(3'b010, 4'd0);
        chk("idle_done_valid", 32'(valid), 32'd1);
        chk("idle_done_value", 32'(value), 32'd0);

        // Async reset mid-debounce with a held key
        press(3'b100, 4'd0);
        digit(4'd9); digit(4'd8);
        chk("v98", 32'(value), 32'd98);
        digit_in = 4'd1;
        keys_n = 3'b110;
        cyc(3);
        reset = 1'b1;
        #1;
        chk("async_value", 32'(value), 32'd0);
        chk("async_count", 32'(digit_count), 32'd0);
        chk("async_echo", 32'(bcd_echo), 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(30);
        chk("held_value", 32'(value), 32'd0);
        chk("held_count", 32'(digit_count), 32'd0);
        keys_n = 3'b111;
        cyc(10);
        digit(4'd1);
        chk("repress_value", 32'(value), 32'd1);
        chk("repress_count", 32'(digit_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
